stump_shift_left_seq: RTL and testbench

//  Multi-cycle left shifter for Stump datapath experiments: left-direction counterpart of the

---
 rtl/stump_shift_left_seq.sv | 124 ++++++++++++
 tb/tb_stump_shift_left_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stump_shift_left_seq.sv
// Multi-cycle left shifter (LSL / ROL / RLC), one bit per clock.
// Start/busy/done handshake; result and carry are held until the next accepted start.
module stump_shift_left_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_A,
    input  logic             c_in,
    input  logic [1:0]       shift_op,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shift_out,
    output logic             c_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_s;
    logic               accept_s;
    logic [CNT_W-1:0]   count_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   shift_out_r;
    logic               c_out_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH:0]     step_s;

    // Single-bit left step of the {carry, value} pair; op 00 leaves both unchanged.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] value,
        input logic             carry,
        input logic [1:0]       op
    );
        logic [WIDTH:0] res;
        case (op)
            2'b01:   res = {value[WIDTH-1], value[WIDTH-2:0], 1'b0};
            2'b10:   res = {value[WIDTH-1], value[WIDTH-2:0], value[WIDTH-1]};
            2'b11:   res = {value[WIDTH-1], value[WIDTH-2:0], carry};
            default: res = {carry, value};
        endcase
        return res;
    endfunction

    // Next-state decode and start acceptance.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    if ((shift_op == 2'b00) || (amount == CNT_ZERO)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (count_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign step_s = shift_step(shift_out_r, c_out_r, op_r);

    // State, handshake flags, counter and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            count_r     <= CNT_ZERO;
            op_r        <= 2'b00;
            shift_out_r <= {WIDTH{1'b0}};
            c_out_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_SHIFT);
            done_r  <= (state_s == ST_DONE);
            if (accept_s) begin
                shift_out_r <= operand_A;
                c_out_r     <= c_in;
                op_r        <= shift_op;
                count_r     <= amount;
            end else if (state_r == ST_SHIFT) begin
                // Leaving SHIFT at count 1 means count never wraps below zero.
                {c_out_r, shift_out_r} <= step_s;
                count_r                <= count_r - CNT_ONE;
            end else begin
                shift_out_r <= shift_out_r;
                c_out_r     <= c_out_r;
                count_r     <= count_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign shift_out = shift_out_r;
    assign c_out     = c_out_r;

endmodule

// File: tb/tb_stump_shift_left_seq.sv
// Self-checking bench for stump_shift_left_seq: directed cases plus randomized
// operations compared against a plain-arithmetic shift/rotate model.
module tb_stump_shift_left_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] operand_A;
    logic        c_in;
    logic [1:0]  shift_op;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] shift_out;
    logic        c_out;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    stump_shift_left_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .operand_A(operand_A), .c_in(c_in),
        .shift_op(shift_op), .amount(amount), .busy(busy), .done(done),
        .shift_out(shift_out), .c_out(c_out)
    );

    always #5 clk = ~clk;

    // Reference: returns {carry, value} after the operation completes.
    function automatic logic [16:0] ref_shift(input logic [15:0] a, input logic c,
                                              input logic [1:0] op, input int amt);
        logic [15:0] v;
        logic        cy;
        logic [16:0] t;
        v = a;
        cy = c;
        if (op == 2'b00) return {c, a};
        for (int i = 0; i < amt; i++) begin
            if (op == 2'b01) begin
                cy = v[15];
                v  = v << 1;
            end else if (op == 2'b10) begin
                cy = v[15];
                v  = (v << 1) | {15'd0, cy};
            end else begin
                t  = {cy, v};
                t  = (t << 1) | (t >> 16);
                cy = t[16];
                v  = t[15:0];
            end
        end
        return {cy, v};
    endfunction

    task automatic start_now(input logic [15:0] a, input logic c, input logic [1:0] op,
                             input logic [3:0] amt);
        operand_A = a;
        c_in      = c;
        shift_op  = op;
        amount    = amt;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        operand_A = 16'($urandom);
        c_in      = 1'($urandom);
        shift_op  = 2'($urandom);
        amount    = 4'($urandom);
    endtask

    task automatic do_start(input logic [15:0] a, input logic c, input logic [1:0] op,
                            input logic [3:0] amt);
        @(negedge clk);
        start_now(a, c, op, amt);
    endtask

    // Counts cycles (sampled at negedge) until done; cyc = -1 on timeout.
    task automatic wait_done(output int cyc, output int busy_n);
        cyc = -1;
        busy_n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        operand_A = 16'h0;
        c_in = 1'b0;
        shift_op = 2'b00;
        amount = 4'd0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({busy, done, c_out, shift_out} !== 19'd0) $display("FAIL reset_state: got %h expected 0", {busy, done, c_out, shift_out});
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_directed;
        int cyc, bn;
        logic [16:0] exp;
        // LSL by one
        do_start(16'h8001, 1'b0, 2'b01, 4'd1);
        wait_done(cyc, bn);
        chk_cnt++;
        if (cyc !== 2) $display("FAIL lsl1_latency: got %0d expected 2", cyc); else pass_cnt++;
        chk_cnt++;
        if ({c_out, shift_out} !== 17'h10002) $display("FAIL lsl1_result: got %h expected 10002", {c_out, shift_out}); else pass_cnt++;
        // ROL by four
        do_start(16'h8001, 1'b1, 2'b10, 4'd4);
        wait_done(cyc, bn);
        chk_cnt++;
        if (cyc !== 5 || bn !== 4) $display("FAIL rol4_timing: got cyc %0d busy %0d expected 5/4", cyc, bn); else pass_cnt++;
        chk_cnt++;
        if ({c_out, shift_out} !== 17'h00018) $display("FAIL rol4_result: got %h expected 00018", {c_out, shift_out}); else pass_cnt++;
        // RLC by two and by the maximum amount
        do_start(16'hC000, 1'b1, 2'b11, 4'd2);
        wait_done(cyc, bn);
        chk_cnt++;
        if (cyc !== 3 || {c_out, shift_out} !== 17'h10003) $display("FAIL rlc2: got cyc %0d val %h expected 3/10003", cyc, {c_out, shift_out}); else pass_cnt++;
        do_start(16'hC000, 1'b1, 2'b11, 4'd15);
        wait_done(cyc, bn);
        exp = ref_shift(16'hC000, 1'b1, 2'b11, 15);
        chk_cnt++;
        if (cyc !== 16 || {c_out, shift_out} !== exp) $display("FAIL rlc15: got cyc %0d val %h expected 16/%h", cyc, {c_out, shift_out}, exp); else pass_cnt++;
        // zero amount and no-op pass-through
        do_start(16'h1234, 1'b1, 2'b01, 4'd0);
        wait_done(cyc, bn);
        chk_cnt++;
        if (cyc !== 1 || bn !== 0 || {c_out, shift_out} !== 17'h11234) $display("FAIL lsl0: got cyc %0d val %h expected 1/11234", cyc, {c_out, shift_out}); else pass_cnt++;
        do_start(16'h1234, 1'b1, 2'b00, 4'd7);
        wait_done(cyc, bn);
        chk_cnt++;
        if (cyc !== 1 || bn !== 0 || {c_out, shift_out} !== 17'h11234) $display("FAIL nop7: got cyc %0d val %h expected 1/11234", cyc, {c_out, shift_out}); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int cyc, bn;
        do_start(16'h8001, 1'b0, 2'b10, 4'd4);
        @(negedge clk);
        @(negedge clk);
        start_now(16'hFFFF, 1'b1, 2'b01, 4'd1);
        wait_done(cyc, bn);
        chk_cnt++;
        if (cyc !== 3) $display("FAIL busy_ignore_latency: got %0d expected 3", cyc); else pass_cnt++;
        chk_cnt++;
        if ({c_out, shift_out} !== 17'h00018) $display("FAIL busy_ignore_result: got %h expected 00018", {c_out, shift_out}); else pass_cnt++;
        start_now(16'hC000, 1'b1, 2'b11, 4'd2);
        wait_done(cyc, bn);
        chk_cnt++;
        if (cyc !== 3 || {c_out, shift_out} !== 17'h10003) $display("FAIL b2b_second: got cyc %0d val %h expected 3/10003", cyc, {c_out, shift_out}); else pass_cnt++;
    endtask

    task automatic test_reset_midshift;
        int cyc, bn;
        logic saw_done;
        logic [16:0] exp;
        do_start(16'hA5A5, 1'b1, 2'b01, 4'd10);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if ({busy, done, c_out, shift_out} !== 19'd0) $display("FAIL async_reset: got %h expected 0", {busy, done, c_out, shift_out}); else pass_cnt++;
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk_cnt++;
        if (saw_done !== 1'b0) $display("FAIL reset_no_done: got %b expected 0", saw_done); else pass_cnt++;
        do_start(16'h0F0F, 1'b0, 2'b10, 4'd3);
        wait_done(cyc, bn);
        exp = ref_shift(16'h0F0F, 1'b0, 2'b10, 3);
        chk_cnt++;
        if (cyc !== 4 || {c_out, shift_out} !== exp) $display("FAIL post_reset_op: got cyc %0d val %h expected 4/%h", cyc, {c_out, shift_out}, exp); else pass_cnt++;
    endtask

    task automatic test_random;
        int cyc, bn, n;
        logic [15:0] a;
        logic        c;
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [16:0] exp;
        for (int k = 0; k < 40; k++) begin
            a   = 16'($urandom);
            c   = 1'($urandom);
            op  = 2'($urandom);
            amt = 4'($urandom_range(0, 15));
            n   = (op == 2'b00) ? 0 : int'(amt);
            exp = ref_shift(a, c, op, int'(amt));
            do_start(a, c, op, amt);
            wait_done(cyc, bn);
            chk_cnt++;
            if (cyc !== n + 1 || bn !== n) $display("FAIL rand_timing[%0d]: got cyc %0d busy %0d expected %0d/%0d", k, cyc, bn, n + 1, n); else pass_cnt++;
            chk_cnt++;
            if ({c_out, shift_out} !== exp) $display("FAIL rand_result[%0d] op %0d amt %0d: got %h expected %h", k, op, amt, {c_out, shift_out}, exp); else pass_cnt++;
            @(negedge clk);
            chk_cnt++;
            if (done !== 1'b0 || {c_out, shift_out} !== exp) $display("FAIL rand_hold[%0d]: got done %b val %h expected 0/%h", k, done, {c_out, shift_out}, exp); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midshift();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
